// File: rtl/fifo_pkg.sv
// Shared defaults and requester encoding for the arbitrated FIFO write front end.
package fifo_pkg;

  localparam int unsigned DATASIZE_DEF = 8;
  localparam int unsigned ADDRSIZE_DEF = 4;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_idx_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: favours the requester that did not win the last accepted write.
module rr_arb2
  import fifo_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_e   last_win,
  input  logic       block,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (!block) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_win == REQ0) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// FIFO pointer/status control with two arbitrated write requesters; memory lives outside.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned DATASIZE = DATASIZE_DEF,
  parameter int unsigned ADDRSIZE = ADDRSIZE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                req1,
  input  logic [DATASIZE-1:0] wdata0,
  input  logic [DATASIZE-1:0] wdata1,
  output logic                gnt0,
  output logic                gnt1,
  input  logic                rd_en,
  output logic                full,
  output logic                empty,
  output logic [ADDRSIZE:0]   count,
  output logic [DATASIZE-1:0] mem_wdata,
  output logic [ADDRSIZE-1:0] mem_waddr,
  output logic [ADDRSIZE-1:0] mem_raddr,
  output logic                mem_wclken,
  output logic                mem_wfull
);

  localparam int unsigned PW = ADDRSIZE + 1;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  req_idx_e      last_q, last_d;
  logic [1:0]    gnt;
  logic          wr_acc;
  logic          rd_acc;

  // Status is purely a function of the registered pointers.
  assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                 (wptr_q[ADDRSIZE-1:0] == rptr_q[ADDRSIZE-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign count = wptr_q - rptr_q;

  rr_arb2 u_arb (
    .req      ({req1, req0}),
    .last_win (last_q),
    .block    (full),
    .gnt      (gnt)
  );

  assign gnt0       = gnt[0];
  assign gnt1       = gnt[1];
  assign wr_acc     = gnt0 | gnt1;
  assign rd_acc     = rd_en & ~empty;

  assign mem_wclken = wr_acc;
  assign mem_wdata  = gnt1 ? wdata1 : wdata0;
  assign mem_waddr  = wptr_q[ADDRSIZE-1:0];
  assign mem_raddr  = rptr_q[ADDRSIZE-1:0];
  assign mem_wfull  = full;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    last_d = last_q;
    if (wr_acc) begin
      wptr_d = wptr_q + PW'(1);
      last_d = gnt1 ? REQ1 : REQ0;
    end
    if (rd_acc) begin
      rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      last_q <= REQ0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      last_q <= last_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a queue-based reference model and a local memory image.
module tb_fifo_wr_arbiter;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int PMOD  = 32;

  logic          clk    = 1'b0;
  logic          rst    = 1'b0;
  logic          req0   = 1'b0;
  logic          req1   = 1'b0;
  logic          rd_en  = 1'b0;
  logic [DW-1:0] wdata0 = '0;
  logic [DW-1:0] wdata1 = '0;
  logic          gnt0, gnt1, full, empty, mem_wclken, mem_wfull;
  logic [AW:0]   count;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] mem_waddr, mem_raddr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] tbmem [DEPTH];

  // Reference model: FIFO contents, total pointer positions, last winner.
  logic [DW-1:0] mq [$];
  int            m_wr   = 0;
  int            m_rd   = 0;
  bit            m_last = 1'b0;

  fifo_wr_arbiter #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .rd_en      (rd_en),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .mem_wdata  (mem_wdata),
    .mem_waddr  (mem_waddr),
    .mem_raddr  (mem_raddr),
    .mem_wclken (mem_wclken),
    .mem_wfull  (mem_wfull)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stand-in for the external memory, written exactly as the integration would.
  always @(posedge clk) begin
    if (!rst && mem_wclken) tbmem[mem_waddr] <= mem_wdata;
  end

  // Per-cycle comparison against the model, then advance the model across the coming edge.
  always @(negedge clk) begin
    bit            eg0, eg1;
    int            occ;
    logic [DW-1:0] exp_wd;
    if (rst) begin
      mq.delete();
      m_wr   = 0;
      m_rd   = 0;
      m_last = 1'b0;
    end
    occ = mq.size();
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (occ < DEPTH) begin
      if (req0 && req1) begin
        if (m_last) eg0 = 1'b1;
        else        eg1 = 1'b1;
      end else if (req0) eg0 = 1'b1;
      else if (req1)     eg1 = 1'b1;
    end
    exp_wd = eg1 ? wdata1 : wdata0;
    check("gnt0",       32'(gnt0),       32'(eg0));
    check("gnt1",       32'(gnt1),       32'(eg1));
    check("full",       32'(full),       32'(occ == DEPTH));
    check("mem_wfull",  32'(mem_wfull),  32'(occ == DEPTH));
    check("empty",      32'(empty),      32'(occ == 0));
    check("count",      32'(count),      32'(occ));
    check("mem_waddr",  32'(mem_waddr),  32'(m_wr % DEPTH));
    check("mem_raddr",  32'(mem_raddr),  32'(m_rd % DEPTH));
    check("mem_wclken", 32'(mem_wclken), 32'(eg0 | eg1));
    check("mem_wdata",  32'(mem_wdata),  32'(exp_wd));
    if (!rst) begin
      if (rd_en && occ > 0) begin
        check("rd_data", 32'(tbmem[mem_raddr]), 32'(mq[0]));
        void'(mq.pop_front());
        m_rd = (m_rd + 1) % PMOD;
      end
      if (eg0 || eg1) begin
        mq.push_back(exp_wd);
        m_wr   = (m_wr + 1) % PMOD;
        m_last = eg1;
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    repeat (2) step();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_gnt0",  32'(gnt0),  32'd0);
    req0 = 1'b1;
    #1;
    check("rst_gnt0_req",   32'(gnt0),       32'd1);
    check("rst_wclken_req", 32'(mem_wclken), 32'd1);
    req0 = 1'b0;

    // Contention from reset: last winner resets to REQ0, so REQ1 takes the first slot.
    rst  = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wdata0 = 8'h10 + 8'(k);
      wdata1 = 8'h80 + 8'(k);
      #1;
      check("cont_gnt1",  32'(gnt1),      32'(k % 2 == 0));
      check("cont_gnt0",  32'(gnt0),      32'(k % 2 == 1));
      check("cont_waddr", 32'(mem_waddr), 32'(k));
      step();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    #1;
    check("cont_count", 32'(count), 32'd5);
    for (int k = 0; k < 5; k++) begin
      check("cont_mem", 32'(tbmem[k]), (k % 2 == 0) ? 32'(8'h80 + 8'(k)) : 32'(8'h10 + 8'(k)));
    end

    // Asynchronous reset mid-stream takes effect before any clock edge.
    rst = 1'b1;
    #1;
    check("amid_count", 32'(count), 32'd0);
    check("amid_empty", 32'(empty), 32'd1);
    check("amid_full",  32'(full),  32'd0);
    step();
    rst = 1'b0;

    // Fill with requester 1 only.
    req1 = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wdata1 = 8'hA0 + 8'(i);
      step();
    end
    wdata1 = 8'hEE;
    #1;
    check("fill_full",   32'(full),       32'd1);
    check("fill_count",  32'(count),      32'd16);
    check("fill_gnt1",   32'(gnt1),       32'd0);
    check("fill_wclken", 32'(mem_wclken), 32'd0);
    step();
    check("fill_hold_count", 32'(count),     32'd16);
    check("fill_hold_waddr", 32'(mem_waddr), 32'd0);
    check("fill_no_17th",    32'(tbmem[0]),  32'h000000A0);
    req1 = 1'b0;

    // Full with a read in the same cycle: write blocked until the next cycle.
    req0   = 1'b1;
    wdata0 = 8'h55;
    rd_en  = 1'b1;
    #1;
    check("fr_gnt0_blocked", 32'(gnt0), 32'd0);
    step();
    rd_en = 1'b0;
    check("fr_count", 32'(count), 32'd15);
    check("fr_full",  32'(full),  32'd0);
    check("fr_gnt0",  32'(gnt0),  32'd1);
    step();
    req0 = 1'b0;
    check("fr_refull", 32'(full), 32'd1);

    // Drain, then read while empty.
    rd_en = 1'b1;
    repeat (DEPTH) step();
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_count", 32'(count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("er_empty", 32'(empty),     32'd1);
      check("er_count", 32'(count),     32'd0);
      check("er_raddr", 32'(mem_raddr), 32'd1);
    end
    rd_en = 1'b0;

    // 40 writes with reads interleaved so both pointers wrap past 31.
    for (int i = 0; i < 40; i++) begin
      req0   = (i % 2 == 0);
      req1   = (i % 2 == 1);
      wdata0 = 8'h20 + 8'(i);
      wdata1 = 8'h60 + 8'(i);
      rd_en  = (i >= 2);
      step();
    end
    req0  = 1'b0;
    req1  = 1'b0;
    rd_en = 1'b1;
    repeat (2) step();
    rd_en = 1'b0;
    check("wrap_empty", 32'(empty),     32'd1);
    check("wrap_count", 32'(count),     32'd0);
    check("wrap_waddr", 32'(mem_waddr), 32'd9);
    check("wrap_raddr", 32'(mem_raddr), 32'd9);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
